// File: rtl/spi_bus_arbiter_if.sv
// Bundle between the config engines, the arbiter and spi_master.
// slave = arbiter side, master = requesters / spi_master side.
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ         = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]                 i_req;
    logic [NUM_REQ-1:0]                 o_gnt;
    logic [NUM_REQ-1:0]                 i_wr_cmd;
    logic [NUM_REQ-1:0]                 i_rd_cmd;
    logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_wr_data;
    logic [NUM_REQ-1:0]                 o_busy;
    logic [MISO_DATA_WIDTH:0]           o_rd_data;
    logic [NUM_REQ-1:0]                 o_cs_n;
    logic                               o_spi_wr_cmd;
    logic                               o_spi_rd_cmd;
    logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data;
    logic                               i_spi_busy;
    logic                               i_spi_ncs;
    logic [MISO_DATA_WIDTH:0]           i_spi_rd_data;
    logic                               o_cmd_drop;
    logic                               o_timeout;

    modport slave (
        input  i_req, i_wr_cmd, i_rd_cmd, i_wr_data, i_spi_busy, i_spi_ncs, i_spi_rd_data,
        output o_gnt, o_busy, o_rd_data, o_cs_n, o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data,
               o_cmd_drop, o_timeout
    );

    modport master (
        output i_req, i_wr_cmd, i_rd_cmd, i_wr_data, i_spi_busy, i_spi_ncs, i_spi_rd_data,
        input  o_gnt, o_busy, o_rd_data, o_cs_n, o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data,
               o_cmd_drop, o_timeout
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin, session-based owner selection for the shared spi_master.
// The owner's commands pass straight through; everyone else is blocked and
// flagged. A session that overstays TIMEOUT_CYCLES is revoked and masked.
module spi_bus_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic             clk,
    input  logic             rstn,
    spi_bus_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RD_W  = MISO_DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;

    logic [PTR_W-1:0]           g_idx;
    logic [PTR_W-1:0]           nxt_ptr;
    logic [NUM_REQ-1:0]         elig;
    logic [NUM_REQ-1:0]         win_oh;
    logic                       req_g;
    logic                       in_grant;
    logic                       timeout_hit;
    logic [MOSI_DATA_WIDTH-1:0] wr_data;
    logic [RD_W-1:0]            rd_data;

    assign in_grant    = (state_q == ST_GRANT);
    assign req_g       = |(gnt_q & bus.i_req);
    assign elig        = bus.i_req & ~mask_q;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_grant && req_g && (cnt_q == TO_LAST);
    assign nxt_ptr     = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);

    // Encode the one-hot owner and select its write word.
    always_comb begin
        g_idx   = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                g_idx   = PTR_W'(i);
                wr_data = bus.i_wr_data[i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            end
        end
    end

    // Round-robin winner: first eligible at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        logic found;
        win_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i]) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Session FSM, timeout counter and masking of revoked requesters.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        // a mask only survives while the requester keeps its request up
        mask_d   = mask_q & bus.i_req;
        case (state_q)
            ST_IDLE: begin
                if (|elig && !bus.i_spi_busy) begin
                    gnt_d   = win_oh;
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!req_g) begin
                    rr_ptr_d = nxt_ptr;
                    if (bus.i_spi_busy) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (timeout_hit) begin
                    rr_ptr_d = nxt_ptr;
                    state_d  = ST_DRAIN;
                    mask_d   = mask_d | gnt_q;
                end
            end
            ST_DRAIN: begin
                if (!bus.i_spi_busy) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Any command that does not reach spi_master is flagged one cycle later;
    // outside GRANT nobody owns the bus, so every command is discarded.
    always_comb begin
        if (in_grant)
            drop_d = |(~gnt_q & (bus.i_wr_cmd | bus.i_rd_cmd)) | |(gnt_q & bus.i_wr_cmd & bus.i_rd_cmd);
        else
            drop_d = |(bus.i_wr_cmd | bus.i_rd_cmd);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            mask_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            mask_q   <= mask_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign rd_data           = bus.i_spi_rd_data;
    assign bus.o_rd_data     = rd_data;
    assign bus.o_gnt         = gnt_q;
    assign bus.o_cs_n        = ~gnt_q | {NUM_REQ{bus.i_spi_ncs}};
    assign bus.o_busy        = ~gnt_q | {NUM_REQ{bus.i_spi_busy | (state_q == ST_DRAIN)}};
    assign bus.o_spi_wr_cmd  = in_grant & |(gnt_q & bus.i_wr_cmd);
    assign bus.o_spi_rd_cmd  = in_grant & |(gnt_q & bus.i_rd_cmd) & ~|(gnt_q & bus.i_wr_cmd);
    assign bus.o_spi_wr_data = wr_data;
    assign bus.o_cmd_drop    = drop_q;
    assign bus.o_timeout     = timeout_hit;
endmodule
